// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the bus-CPU T-state sequencer:
// opcodes, control-word bit map, idle word and state encoding.
package cpu_seq_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int CB_CP   = 14;
   localparam int CB_EP   = 13;
   localparam int CB_LP   = 12;
   localparam int CB_NLMA = 11;
   localparam int CB_NLMD = 10;
   localparam int CB_NCE  = 9;
   localparam int CB_NLR  = 8;
   localparam int CB_NLI  = 7;
   localparam int CB_NEI  = 6;
   localparam int CB_NLA  = 5;
   localparam int CB_EA   = 4;
   localparam int CB_SUB  = 3;
   localparam int CB_EU   = 2;
   localparam int CB_NLB  = 1;
   localparam int CB_NLO  = 0;

   localparam logic [14:0] CTRL_IDLE = 15'h0FE3;

   typedef enum logic [3:0] {
      S_WAIT = 4'd0,
      T1     = 4'd1,
      T2     = 4'd2,
      T3     = 4'd3,
      T4     = 4'd4,
      T5     = 4'd5,
      T6     = 4'd6,
      T7     = 4'd7,
      T8     = 4'd8,
      S_HALT = 4'd15
   } state_e;

   // Inverting a bit of the idle word asserts it, whatever its polarity.
   function automatic logic [14:0] flip(
      input logic [14:0] c,
      input int          b
   );
      return c ^ (15'd1 << b);
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer-side bundle: IR opcode, ALU flags, step handshake
// in; control word, T-state and status out.
interface cpu_sequencer_if;

   logic [3:0]  opcode;
   logic        cf;
   logic        zf;
   logic        step_mode;
   logic        step_req;
   logic [14:0] ctrl;
   logic [2:0]  tstate;
   logic        step_ack;
   logic        halted;

   modport master (
      output opcode, cf, zf, step_mode, step_req,
      input  ctrl, tstate, step_ack, halted
   );

   modport slave (
      input  opcode, cf, zf, step_mode, step_req,
      output ctrl, tstate, step_ack, halted
   );

endinterface

// File: rtl/cpu_seq_ucode.sv
// Combinational microcode: T-state, opcode and flags in,
// control word and last-state marker out.
module cpu_seq_ucode
   import cpu_seq_pkg::*;
#(
   parameter bit FIXED_LEN = 1'b0,
   parameter int MAX_T     = 6
) (
   input  logic [3:0]  opcode_i,
   input  state_e      t_i,
   input  logic        cf_i,
   input  logic        zf_i,
   output logic [14:0] ctrl_o,
   output logic        last_o
);

   logic       mem_rd;
   logic       jmp_tk;
   logic       is_ldi;
   logic       is_out;
   logic [3:0] lt;
   logic [3:0] tn;

   always_comb begin
      mem_rd = (opcode_i == OP_LDA) || (opcode_i == OP_ADD)
            || (opcode_i == OP_SUB) || (opcode_i == OP_STA);
      jmp_tk = (opcode_i == OP_JMP)
            || ((opcode_i == OP_JC) && cf_i)
            || ((opcode_i == OP_JZ) && zf_i);
      is_ldi = opcode_i == OP_LDI;
      is_out = opcode_i == OP_OUT;
      tn     = 4'(t_i);

      lt = 4'd3;
      unique case (opcode_i)
         OP_LDA:                         lt = 4'd5;
         OP_ADD, OP_SUB, OP_STA:         lt = 4'd6;
         OP_LDI, OP_JMP, OP_OUT, OP_HLT: lt = 4'd4;
         OP_JC, OP_JZ:                   lt = jmp_tk ? 4'd4 : 4'd3;
         default:                        lt = 4'd3;
      endcase

      ctrl_o = CTRL_IDLE;
      unique case (t_i)
         T1: ctrl_o = flip(flip(CTRL_IDLE, CB_EP), CB_NLMA);
         T2: ctrl_o = flip(CTRL_IDLE, CB_CP);
         T3: ctrl_o = flip(flip(CTRL_IDLE, CB_NCE), CB_NLI);
         T4: begin
            unique case (1'b1)
               mem_rd: ctrl_o = flip(flip(CTRL_IDLE, CB_NEI), CB_NLMA);
               is_ldi: ctrl_o = flip(flip(CTRL_IDLE, CB_NEI), CB_NLA);
               jmp_tk: ctrl_o = flip(flip(CTRL_IDLE, CB_NEI), CB_LP);
               is_out: ctrl_o = flip(flip(CTRL_IDLE, CB_EA), CB_NLO);
               default: ;
            endcase
         end
         T5: begin
            unique case (opcode_i)
               OP_LDA:         ctrl_o = flip(flip(CTRL_IDLE, CB_NCE), CB_NLA);
               OP_ADD, OP_SUB: ctrl_o = flip(flip(CTRL_IDLE, CB_NCE), CB_NLB);
               OP_STA:         ctrl_o = flip(flip(CTRL_IDLE, CB_EA), CB_NLMD);
               default: ;
            endcase
         end
         T6: begin
            unique case (opcode_i)
               OP_ADD: ctrl_o = flip(flip(CTRL_IDLE, CB_EU), CB_NLA);
               OP_SUB: ctrl_o = flip(flip(flip(CTRL_IDLE, CB_EU), CB_NLA), CB_SUB);
               OP_STA: ctrl_o = flip(CTRL_IDLE, CB_NLR);
               default: ;
            endcase
         end
         default: ;
      endcase

      // >= rather than == so a flag or opcode change mid-instruction
      // can never strand the counter past its end state.
      if (FIXED_LEN)
         last_o = tn >= 4'(MAX_T);
      else
         last_o = (tn >= lt) || (tn >= 4'(MAX_T));
   end

endmodule

// File: rtl/cpu_sequencer.sv
// T-state sequencer top: state register, WAIT/HALT handling and
// single-step acknowledge around the microcode decoder.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter bit FIXED_LEN = 1'b0,
   parameter int MAX_T     = 6,
   parameter bit STEP_EN   = 1'b1
) (
   input logic            clk,
   input logic            rst,
   cpu_sequencer_if.slave bus
);

   state_e      state_q, state_d;
   logic        stepped_q, stepped_d;
   logic [14:0] uc_ctrl;
   logic        uc_last;
   logic        smode;
   logic        run;
   logic        hlt;
   logic        lst;
   logic [4:0]  drv;

   cpu_seq_ucode #(
      .FIXED_LEN (FIXED_LEN),
      .MAX_T     (MAX_T)
   ) u_ucode (
      .opcode_i (bus.opcode),
      .t_i      (state_q),
      .cf_i     (bus.cf),
      .zf_i     (bus.zf),
      .ctrl_o   (uc_ctrl),
      .last_o   (uc_last)
   );

   assign smode = STEP_EN && bus.step_mode;

   always_comb begin
      run       = (state_q != S_WAIT) && (state_q != S_HALT);
      hlt       = (state_q == T4) && (bus.opcode == OP_HLT);
      lst       = run && uc_last && !hlt;
      state_d   = state_q;
      stepped_d = stepped_q;
      unique case (1'b1)
         state_q == S_HALT: ;
         state_q == S_WAIT: begin
            if (bus.step_req) begin
               state_d   = T1;
               stepped_d = 1'b1;
            end
         end
         hlt: state_d = S_HALT;
         lst: begin
            state_d   = smode ? S_WAIT : T1;
            stepped_d = 1'b0;
         end
         default: state_d = state_e'(state_q + 4'd1);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= smode ? S_WAIT : T1;
         stepped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stepped_q <= stepped_d;
      end
   end

   assign bus.ctrl     = (rst || !run) ? CTRL_IDLE : uc_ctrl;
   assign bus.tstate   = run ? state_q[2:0] : 3'd0;
   assign bus.halted   = !rst && (state_q == S_HALT);
   assign bus.step_ack = STEP_EN && !rst && stepped_q
                      && (lst || hlt);

   assign drv = {bus.ctrl[CB_EP], ~bus.ctrl[CB_NCE],
                 ~bus.ctrl[CB_NEI], bus.ctrl[CB_EA],
                 bus.ctrl[CB_EU]};

   a_bus_one: assert property (@(posedge clk) disable iff (rst)
      $countones(drv) <= 1);

   a_t_max: assert property (@(posedge clk) disable iff (rst)
      !run || (4'(state_q) <= 4'(MAX_T)));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: variable-length and fixed-length sequencers
// driven by directed instructions plus a random invariant sweep.
module tb_cpu_sequencer;

   localparam logic [14:0] IDLE = 15'h0FE3;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cpu_sequencer_if ia ();
   cpu_sequencer_if ib ();

   cpu_sequencer #(
      .FIXED_LEN (1'b0),
      .MAX_T     (6),
      .STEP_EN   (1'b1)
   ) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ia)
   );

   cpu_sequencer #(
      .FIXED_LEN (1'b1),
      .MAX_T     (6),
      .STEP_EN   (1'b1)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ib)
   );

   typedef struct {
      logic        sel;
      logic        chk;
      logic [14:0] c;
      logic [2:0]  t;
      logic        a;
      logic        h;
      int          tag;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   logic [14:0] g_c;
   logic [2:0]  g_t;
   logic        g_a;
   logic        g_h;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         me = sb.pop_front();
         if (me.chk) begin
            g_c = me.sel ? ib.ctrl : ia.ctrl;
            g_t = me.sel ? ib.tstate : ia.tstate;
            g_a = me.sel ? ib.step_ack : ia.step_ack;
            g_h = me.sel ? ib.halted : ia.halted;
            total++;
            if ({g_c, g_t, g_a, g_h} !== {me.c, me.t, me.a, me.h}) begin
               bad++;
               $display("FAIL tag%0d dut%0d ctrl=%h want %h t=%0d want %0d ack=%b want %b halt=%b want %b",
                  me.tag, me.sel, g_c, me.c, g_t, me.t, g_a, me.a, g_h, me.h);
            end
         end
      end
   end

   function automatic logic [14:0] ectl(input logic [3:0] op, input int t,
                                        input logic c, input logic z);
      if (t == 1) return 15'h27E3;
      if (t == 2) return 15'h4FE3;
      if (t == 3) return 15'h0D63;
      if (t == 4) begin
         case (op)
            4'h1, 4'h2, 4'h3, 4'h4: return 15'h07A3;
            4'h5: return 15'h0F83;
            4'h6: return 15'h1FA3;
            4'h7: return c ? 15'h1FA3 : IDLE;
            4'h8: return z ? 15'h1FA3 : IDLE;
            4'hE: return 15'h0FF2;
            default: return IDLE;
         endcase
      end
      if (t == 5) begin
         case (op)
            4'h1: return 15'h0DC3;
            4'h2, 4'h3: return 15'h0DE1;
            4'h4: return 15'h0BF3;
            default: return IDLE;
         endcase
      end
      if (t == 6) begin
         case (op)
            4'h2: return 15'h0FC7;
            4'h3: return 15'h0FCF;
            4'h4: return 15'h0EE3;
            default: return IDLE;
         endcase
      end
      return IDLE;
   endfunction

   function automatic int elen(input logic [3:0] op, input logic c,
                               input logic z, input logic fx);
      if (op == 4'hF) return 4;
      if (fx) return 6;
      case (op)
         4'h1: return 5;
         4'h2, 4'h3, 4'h4: return 6;
         4'h5, 4'h6, 4'hE: return 4;
         4'h7: return c ? 4 : 3;
         4'h8: return z ? 4 : 3;
         default: return 3;
      endcase
   endfunction

   task automatic cyc(input logic s, input logic k, input logic [14:0] c,
                      input logic [2:0] t, input logic a, input logic h,
                      input int tag);
      exp_t e;
      e.sel = s;
      e.chk = k;
      e.c   = c;
      e.t   = t;
      e.a   = a;
      e.h   = h;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic s, input logic [3:0] op, input logic c,
                        input logic z, input logic stp, input int tag);
      int n;
      n = elen(op, c, z, s);
      if (s) begin
         ib.opcode = op;
         ib.cf     = c;
         ib.zf     = z;
      end else begin
         ia.opcode = op;
         ia.cf     = c;
         ia.zf     = z;
      end
      for (int t = 1; t <= n; t++)
         cyc(s, 1'b1, ectl(op, t, c, z), 3'(t), stp && (t == n), 1'b0, tag);
   endtask

   logic [4:0] drv;

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ia.opcode = 4'h0; ia.cf = 1'b0; ia.zf = 1'b0;
      ia.step_mode = 1'b0; ia.step_req = 1'b0;
      ib.opcode = 4'h0; ib.cf = 1'b0; ib.zf = 1'b0;
      ib.step_mode = 1'b0; ib.step_req = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b0, 1'b1, IDLE, 3'd1, 1'b0, 1'b0, 1);
      cyc(1'b0, 1'b1, IDLE, 3'd1, 1'b0, 1'b0, 2);
      rst_a = 1'b0;

      instr(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10);
      instr(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 11);
      instr(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 12);
      instr(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 13);
      instr(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 14);
      instr(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 15);
      instr(1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 16);
      instr(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 17);
      instr(1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 18);
      instr(1'b0, 4'h7, 1'b0, 1'b1, 1'b0, 19);
      instr(1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 20);
      instr(1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 21);
      instr(1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 22);

      ia.opcode = 4'h2;
      for (int t = 1; t <= 4; t++)
         cyc(1'b0, 1'b1, ectl(4'h2, t, 1'b0, 1'b0), 3'(t), 1'b0, 1'b0, 30);
      rst_a = 1'b1;
      cyc(1'b0, 1'b1, IDLE, 3'd5, 1'b0, 1'b0, 31);
      rst_a = 1'b0;
      instr(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32);

      ia.step_mode = 1'b1;
      instr(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 40);
      for (int i = 0; i < 10; i++)
         cyc(1'b0, 1'b1, IDLE, 3'd0, 1'b0, 1'b0, 41);
      ia.opcode   = 4'h2;
      ia.step_req = 1'b1;
      cyc(1'b0, 1'b1, IDLE, 3'd0, 1'b0, 1'b0, 42);
      ia.step_req = 1'b0;
      instr(1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 43);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, IDLE, 3'd0, 1'b0, 1'b0, 44);
      ia.step_mode = 1'b0;
      ia.step_req  = 1'b1;
      cyc(1'b0, 1'b1, IDLE, 3'd0, 1'b0, 1'b0, 45);
      ia.step_req = 1'b0;
      instr(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 46);
      instr(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 47);

      instr(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 50);
      for (int i = 0; i < 20; i++) begin
         ia.step_req = 1'(i % 2);
         cyc(1'b0, 1'b1, IDLE, 3'd0, 1'b0, 1'b1, 51);
      end
      ia.step_req = 1'b0;
      rst_a = 1'b1;
      cyc(1'b0, 1'b0, IDLE, 3'd0, 1'b0, 1'b0, 52);
      rst_a = 1'b0;
      instr(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 53);

      rst_a = 1'b1;
      rst_b = 1'b0;
      instr(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 60);
      instr(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 61);
      instr(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 62);
      instr(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 63);
      instr(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 64);
      instr(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 65);
      instr(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 66);
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b1, IDLE, 3'd0, 1'b0, 1'b1, 67);
      rst_b = 1'b1;
      rst_a = 1'b0;

      for (int i = 0; i < 10000; i++) begin
         @(posedge clk);
         #1;
         ia.opcode = 4'($urandom_range(0, 14));
         ia.cf     = 1'($urandom_range(0, 1));
         ia.zf     = 1'($urandom_range(0, 1));
         #1;
         drv = {ia.ctrl[13], ~ia.ctrl[9], ~ia.ctrl[6], ia.ctrl[4], ia.ctrl[2]};
         total++;
         if ($countones(drv) > 1 || ia.tstate == 3'd0 || ia.tstate > 3'd6
             || ia.halted !== 1'b0) begin
            bad++;
            $display("FAIL rand cycle %0d ctrl=%h t=%0d halt=%b want one driver, t 1..6, halt 0",
               i, ia.ctrl, ia.tstate, ia.halted);
         end
      end

      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain left=%0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
